// File: rtl/lcd_pkg.sv
// Shared timing, region and colour constants for the 800x480 LCD dashboard.
package lcd_pkg;

    // Horizontal timing in pixel clocks.
    localparam logic [10:0] H_TOTAL   = 11'd1056;
    localparam logic [10:0] H_LAST    = 11'd1055;
    localparam logic [10:0] H_VISIBLE = 11'd800;
    localparam logic [10:0] H_START   = 11'd216;
    localparam logic [10:0] H_PRE     = 11'd215;   // last blank pixel before x = 0

    // Vertical timing in lines.
    localparam logic [9:0]  V_TOTAL   = 10'd525;
    localparam logic [9:0]  V_LAST    = 10'd524;
    localparam logic [9:0]  V_VISIBLE = 10'd480;
    localparam logic [9:0]  V_START   = 10'd35;

    // Dashboard regions, in visible y coordinates.
    localparam logic [8:0]  DUTY_Y0    = 9'd40;
    localparam logic [8:0]  DUTY_Y1    = 9'd119;
    localparam logic [8:0]  FREQ_Y0    = 9'd160;
    localparam logic [8:0]  FREQ_Y1    = 9'd239;
    localparam logic [8:0]  WAVE_Y0    = 9'd280;
    localparam logic [8:0]  WAVE_Y1    = 9'd439;
    localparam logic [8:0]  WAVE_HI_Y0 = 9'd290;
    localparam logic [8:0]  WAVE_HI_Y1 = 9'd299;
    localparam logic [8:0]  WAVE_LO_Y0 = 9'd420;
    localparam logic [8:0]  WAVE_LO_Y1 = 9'd429;
    localparam logic [8:0]  HZ_Y0      = 9'd450;
    localparam logic [8:0]  HZ_Y1      = 9'd469;

    // Waveform preview period in pixels and percent ceiling.
    localparam logic [7:0]  P_LAST     = 8'd199;
    localparam logic [7:0]  H_MAX      = 8'd200;
    localparam logic [7:0]  PCT_MAX    = 8'd100;
    localparam logic [11:0] HZ_BAR_MAX = 12'd800;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COL_BLACK = 24'h000000;
    localparam rgb_t COL_GREEN = 24'h00FF00;
    localparam rgb_t COL_GREY  = 24'h202020;
    localparam rgb_t COL_BLUE  = 24'h0000FF;
    localparam rgb_t COL_WHITE = 24'hFFFFFF;
    localparam rgb_t COL_RED   = 24'hFF0000;

    // Saturate a percentage setting at 100.
    function automatic logic [6:0] clamp_pct(input logic [7:0] v);
        return (v > PCT_MAX) ? 7'(PCT_MAX) : v[6:0];
    endfunction

endpackage

// File: rtl/lcd_sync_gen.sv
// Pixel-clock divider, raster counters and sync/enable decode for the LCD panel.
module lcd_sync_gen
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_nclk,
    output logic       o_tick,
    output logic       o_hd_n,
    output logic       o_vd_n,
    output logic       o_den,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic [7:0] o_p
);

    localparam logic [10:0] H_END = 11'(int'(H_START) + H_ACTIVE - 1);
    localparam logic [9:0]  V_END = 10'(int'(V_START) + V_ACTIVE - 1);

    logic        r_nclk;
    logic [10:0] r_hc;
    logic [9:0]  r_vc;
    logic [7:0]  r_p;

    // NCLK toggles every system clock, giving CLK/2.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_nclk <= 1'b0;
        else       r_nclk <= ~r_nclk;
    end

    // Counters step on the cycle where NCLK falls, so NCLK rises mid-pixel.
    assign o_tick = r_nclk;

    // Raster counters plus the x mod 200 counter that is realigned every line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hc <= '0;
            r_vc <= '0;
            r_p  <= '0;
        end else if (o_tick) begin
            if (r_hc == H_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 11'd1;
            end
            if (r_hc == H_PRE)       r_p <= '0;
            else if (r_p == P_LAST)  r_p <= '0;
            else                     r_p <= r_p + 8'd1;
        end
    end

    assign o_nclk = r_nclk;
    assign o_hd_n = (r_hc != 11'd0);
    assign o_vd_n = (r_vc != 10'd0);
    assign o_den  = (r_hc >= H_START) && (r_hc <= H_END) &&
                    (r_vc >= V_START) && (r_vc <= V_END);
    assign o_x    = 10'(r_hc - H_START);
    assign o_y    = 9'(r_vc - V_START);
    assign o_p    = r_p;

endmodule

// File: rtl/visualizacion_pantalla.sv
// LCD dashboard: clamps PWM settings and renders duty/freq/Hz bars and a waveform preview.
module visualizacion_pantalla
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  duty_cycle,
    input  logic [7:0]  pwm_freq,
    input  logic [15:0] freq_Hz,
    output logic        NCLK,
    output logic        GREST,
    output logic        HD,
    output logic        VD,
    output logic        DEN,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B
);

    logic        w_tick;
    logic        w_hd_n;
    logic        w_vd_n;
    logic        w_den;
    logic [9:0]  w_x;
    logic [8:0]  w_y;
    logic [7:0]  w_p;

    logic [6:0]  w_d;
    logic [6:0]  w_f;
    logic [11:0] w_x12;
    logic [11:0] w_duty_lim;
    logic [11:0] w_freq_lim;
    logic [11:0] w_hz_raw;
    logic [11:0] w_hz_lim;
    logic [7:0]  w_h;
    logic        w_wave_white;
    rgb_t        w_rgb;

    logic        r_grest;
    logic        r_hd;
    logic        r_vd;
    logic        r_den;
    rgb_t        r_rgb;

    lcd_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_sync (
        .i_clk  (CLK),
        .i_rst  (RST),
        .o_nclk (NCLK),
        .o_tick (w_tick),
        .o_hd_n (w_hd_n),
        .o_vd_n (w_vd_n),
        .o_den  (w_den),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_p    (w_p)
    );

    assign w_d        = clamp_pct(duty_cycle);
    assign w_f        = clamp_pct(pwm_freq);
    assign w_x12      = {2'b00, w_x};
    assign w_duty_lim = {2'b00, w_d, 3'b000};
    assign w_freq_lim = {2'b00, w_f, 3'b000};
    assign w_hz_raw   = 12'(freq_Hz >> 4);
    assign w_hz_lim   = (w_hz_raw > HZ_BAR_MAX) ? HZ_BAR_MAX : w_hz_raw;
    assign w_h        = {w_d, 1'b0};

    // Square-wave trace: high rail, low rail, and vertical edges when duty is strictly between 0 and 100.
    always_comb begin
        w_wave_white = 1'b0;
        if ((w_p < w_h) && (w_y >= WAVE_HI_Y0) && (w_y <= WAVE_HI_Y1))
            w_wave_white = 1'b1;
        if ((w_p >= w_h) && (w_y >= WAVE_LO_Y0) && (w_y <= WAVE_LO_Y1))
            w_wave_white = 1'b1;
        if ((w_h != 8'd0) && (w_h < H_MAX) && ((w_p == 8'd0) || (w_p == w_h)) &&
            (w_y >= WAVE_HI_Y0) && (w_y <= WAVE_LO_Y1))
            w_wave_white = 1'b1;
    end

    // Pixel colour by region priority; anything outside the visible area is black.
    always_comb begin
        w_rgb = COL_BLACK;
        if (!w_den) begin
            w_rgb = COL_BLACK;
        end else if ((w_y >= DUTY_Y0) && (w_y <= DUTY_Y1)) begin
            w_rgb = (w_x12 < w_duty_lim) ? COL_GREEN : COL_GREY;
        end else if ((w_y >= FREQ_Y0) && (w_y <= FREQ_Y1)) begin
            w_rgb = (w_x12 < w_freq_lim) ? COL_BLUE : COL_GREY;
        end else if ((w_y >= WAVE_Y0) && (w_y <= WAVE_Y1)) begin
            w_rgb = w_wave_white ? COL_WHITE : COL_BLACK;
        end else if ((w_y >= HZ_Y0) && (w_y <= HZ_Y1)) begin
            w_rgb = (w_x12 < w_hz_lim) ? COL_RED : COL_GREY;
        end
    end

    // Panel reset follows RST with one register of delay.
    always_ff @(posedge CLK) begin
        if (RST) r_grest <= 1'b0;
        else     r_grest <= 1'b1;
    end

    // Sync, enable and colour are registered together once per pixel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hd  <= 1'b1;
            r_vd  <= 1'b1;
            r_den <= 1'b0;
            r_rgb <= COL_BLACK;
        end else if (w_tick) begin
            r_hd  <= w_hd_n;
            r_vd  <= w_vd_n;
            r_den <= w_den;
            r_rgb <= w_rgb;
        end
    end

    assign GREST = r_grest;
    assign HD    = r_hd;
    assign VD    = r_vd;
    assign DEN   = r_den;
    assign R     = r_rgb[23:16];
    assign G     = r_rgb[15:8];
    assign B     = r_rgb[7:0];

endmodule

// File: tb/tb_visualizacion_pantalla.sv
// Bench for visualizacion_pantalla: raster model feeding an expected-pixel queue,
// plus whole-frame counts of sync and enable activity.
module tb_visualizacion_pantalla;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  duty_cycle;
    logic [7:0]  pwm_freq;
    logic [15:0] freq_Hz;
    logic        NCLK;
    logic        GREST;
    logic        HD;
    logic        VD;
    logic        DEN;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    always #10 CLK = ~CLK;   // 50 MHz

    visualizacion_pantalla dut (
        .CLK        (CLK),
        .RST        (RST),
        .duty_cycle (duty_cycle),
        .pwm_freq   (pwm_freq),
        .freq_Hz    (freq_Hz),
        .NCLK       (NCLK),
        .GREST      (GREST),
        .HD         (HD),
        .VD         (VD),
        .DEN        (DEN),
        .R          (R),
        .G          (G),
        .B          (B)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_nclk"},  32'(NCLK),    32'd0);
        check({tag, "_grest"}, 32'(GREST),   32'd0);
        check({tag, "_hd"},    32'(HD),      32'd1);
        check({tag, "_vd"},    32'(VD),      32'd1);
        check({tag, "_den"},   32'(DEN),     32'd0);
        check({tag, "_rgb"},   32'({R, G, B}), 32'd0);
    endtask

    // ---------------- reference model ----------------
    // Entry layout: {vc[9:0], hc[10:0], hd, vd, den, rgb[23:0]}
    logic [47:0] exp_q[$];
    logic        m_nclk;
    int          m_hc;
    int          m_vc;

    function automatic bit sel_line(input int vc);
        int y;
        y = vc - 35;
        return (vc inside {0, 1, 2, 34, 35, 36}) ||
               (y inside {80, 81, 82, 83, 170, 171, 172, 295, 296, 297, 298,
                          350, 351, 352, 353, 425, 426, 427, 460, 461, 462, 463});
    endfunction

    function automatic logic [23:0] model_rgb(input int x, input int y, input int duty,
                                              input int pf, input int fhz);
        int d, f, p, h, lim;
        bit white;
        d = (duty > 100) ? 100 : duty;
        f = (pf > 100) ? 100 : pf;
        if (y >= 40 && y <= 119) return (x < d * 8) ? 24'h00FF00 : 24'h202020;
        if (y >= 160 && y <= 239) return (x < f * 8) ? 24'h0000FF : 24'h202020;
        if (y >= 280 && y <= 439) begin
            p = x % 200;
            h = d * 2;
            white = (p < h && y >= 290 && y <= 299) ||
                    (p >= h && y >= 420 && y <= 429) ||
                    (h > 0 && h < 200 && (p == 0 || p == h) && y >= 290 && y <= 429);
            return white ? 24'hFFFFFF : 24'h000000;
        end
        if (y >= 450 && y <= 469) begin
            lim = fhz >> 4;
            if (lim > 800) lim = 800;
            return (x < lim) ? 24'hFF0000 : 24'h202020;
        end
        return 24'h000000;
    endfunction

    function automatic logic [47:0] model_pixel(input int hc, input int vc, input int duty,
                                                input int pf, input int fhz);
        logic        hd, vd, den;
        logic [23:0] rgb;
        hd  = (hc != 0);
        vd  = (vc != 0);
        den = (hc >= 216 && hc <= 1015 && vc >= 35 && vc <= 514);
        rgb = den ? model_rgb(hc - 216, vc - 35, duty, pf, fhz) : 24'h000000;
        return {10'(vc), 11'(hc), hd, vd, den, rgb};
    endfunction

    // Model raster: one pixel per falling-NCLK cycle, expected output queued for chosen lines.
    always @(posedge CLK) begin
        if (RST) begin
            m_nclk <= 1'b0;
            m_hc   <= 0;
            m_vc   <= 0;
        end else begin
            m_nclk <= ~m_nclk;
            if (m_nclk) begin
                if (sel_line(m_vc))
                    exp_q.push_back(model_pixel(m_hc, m_vc, int'(duty_cycle),
                                                int'(pwm_freq), int'(freq_Hz)));
                if (m_hc == 1055) begin
                    m_hc <= 0;
                    m_vc <= (m_vc == 524) ? 0 : m_vc + 1;
                end else begin
                    m_hc <= m_hc + 1;
                end
            end
        end
    end

    // Scoreboard: compare the registered outputs half a clock after each queued pixel.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            check($sformatf("pix vc=%0d hc=%0d", exp_q[0][47:38], exp_q[0][37:27]),
                  {5'b0, HD, VD, DEN, R, G, B}, {5'b0, exp_q[0][26:0]});
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_line(input int vc);
        case (vc - 35)
            80:  duty_cycle = 8'd50;
            81:  duty_cycle = 8'd0;
            82:  duty_cycle = 8'd150;
            83:  duty_cycle = 8'd100;
            170: pwm_freq   = 8'd50;
            171: pwm_freq   = 8'd0;
            172: pwm_freq   = 8'd255;
            295: duty_cycle = 8'd50;
            296: duty_cycle = 8'd0;
            297: duty_cycle = 8'd150;
            298: duty_cycle = 8'($urandom_range(1, 99));
            350: duty_cycle = 8'd50;
            351: duty_cycle = 8'd0;
            352: duty_cycle = 8'd150;
            353: duty_cycle = 8'($urandom_range(1, 99));
            425: duty_cycle = 8'd50;
            426: duty_cycle = 8'd0;
            427: duty_cycle = 8'd150;
            460: freq_Hz    = 16'd100;
            461: freq_Hz    = 16'hFFFF;
            462: freq_Hz    = 16'd0;
            463: freq_Hz    = 16'($urandom_range(0, 16000));
            default: ;
        endcase
    endtask

    // ---------------- main sequence ----------------
    int   den_cnt   = 0;
    int   den_rise  = 0;
    int   hd_fall   = 0;
    int   vd_low    = 0;
    int   blank_bad = 0;
    logic hd_prev   = 1'b1;
    logic den_prev  = 1'b0;
    int   last_vc   = -1;
    bit   found;

    initial begin
        duty_cycle = 8'd50;
        pwm_freq   = 8'd50;
        freq_Hz    = 16'd100;
        RST        = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset("init");
        RST = 1'b0;

        // One full frame (1056 x 525 pixels, two CLK per pixel).
        for (int n = 1; n <= 1108800; n++) begin
            @(negedge CLK);
            if (n <= 6) check($sformatf("nclk_%0d", n), 32'(NCLK), 32'(n % 2));
            if (n == 1) check("grest_release", 32'(GREST), 32'd1);
            if (DEN) den_cnt++;
            if (DEN && !den_prev) den_rise++;
            if (!HD && hd_prev) hd_fall++;
            if (!VD) vd_low++;
            if (!DEN && ({R, G, B} != 24'd0)) blank_bad++;
            hd_prev  = HD;
            den_prev = DEN;
            if (m_hc == 100 && m_vc != last_vc) begin
                last_vc = m_vc;
                apply_line(m_vc);
            end
        end
        check("frame_den_clk",   32'(den_cnt),   32'd768000);
        check("frame_den_lines", 32'(den_rise),  32'd480);
        check("frame_hd_pulses", 32'(hd_fall),   32'd525);
        check("vd_low_clk",      32'(vd_low),    32'd2112);
        check("rgb_in_blank",    32'(blank_bad), 32'd0);

        // Reset in the middle of the next frame.
        found = 1'b0;
        for (int k = 0; k < 20000 && !found; k++) begin
            @(negedge CLK);
            if (m_vc == 3 && m_hc == 500) found = 1'b1;
        end
        check("reach_mid_frame", 32'(found), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_reset("mid");
        RST = 1'b0;
        duty_cycle = 8'd50;
        for (int n = 1; n <= 3 * 2112 + 50; n++) begin
            @(negedge CLK);
            if (n <= 4) check($sformatf("nclk_after_mid_%0d", n), 32'(NCLK), 32'(n % 2));
            if (n == 1) check("grest_after_mid", 32'(GREST), 32'd1);
        end
        @(negedge CLK);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
